crc16_frame_ctrl: RTL and testbench

- Sequences the tag's parallel-output CRC16 checker for every command that carries a CRC16: Select, ReqRN, Read, Write and SensData.
- Sits between the command bit parser and the CRC16 check engine, in the single `clk` domain.
- Per command: clears the engine, streams exactly `cmd_len` bits into it, waits for the final shift to land, then compares the engine state with the Gen2 residue.
- Reports pass/fail to the command decoder with a done pulse.

---
 rtl/crc16_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_crc16_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_ctrl.sv
// Frame sequencer for the Gen2 CRC16 check engine: clears it, streams cmd_len bits, checks the residue.
// Optional macro CRC16_FRAME_STATS_EN adds a saturating err_count output.
module crc16_frame_ctrl #(
  parameter int          LEN_W   = 10,
  parameter logic [15:0] RESIDUE = 16'h1D0F,
  parameter int          MIN_LEN = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [15:0]      crc_in,
  output logic             crc_clr,
  output logic             crc_shift,
  output logic             crc_bit,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
`ifdef CRC16_FRAME_STATS_EN
  output logic [7:0]       err_count,
`endif
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_inc;
  logic             r_crc_clr;
  logic             r_crc_shift;
  logic             r_crc_bit;
  logic             r_done;
  logic             r_crc_ok;
  logic             r_len_err;
  logic             w_start;
  logic             w_short;
  logic             w_bit_acc;

  // bit_valid is a one-sided strobe with no backpressure: a bit is taken only in
  // CLEAR/RUN and only when neither abort nor a restart claims the same cycle.
  always_comb begin
    w_start      = cmd_start && !abort;
    w_short      = cmd_len < MIN_LEN_V;
    w_bit_acc    = bit_valid && !abort && !cmd_start &&
                   ((r_state == S_CLEAR) || (r_state == S_RUN));
    w_count_inc  = r_count + LEN_W'(1);
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else if (cmd_start) begin
      w_next_state = w_short ? S_FAIL : S_CLEAR;
    end else begin
      case (r_state)
        S_CLEAR: w_next_state = (w_bit_acc && (w_count_inc == r_len)) ? S_WAIT : S_RUN;
        S_RUN:   if (w_bit_acc && (w_count_inc == r_len)) w_next_state = S_WAIT;
        S_WAIT:  w_next_state = S_CHECK;
        S_CHECK: w_next_state = S_IDLE;
        S_FAIL:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_crc_clr   <= 1'b1;
      r_crc_shift <= 1'b0;
      r_crc_bit   <= 1'b0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_crc_clr   <= (w_next_state == S_IDLE) || (w_next_state == S_CLEAR);
      r_crc_shift <= w_bit_acc;
      r_crc_bit   <= w_bit_acc & bit_in;
      r_done      <= 1'b0;
      if (w_start) begin
        r_len     <= cmd_len;
        r_count   <= '0;
        r_crc_ok  <= 1'b0;
        r_len_err <= 1'b0;
      end else begin
        if (w_bit_acc) r_count <= w_count_inc;
        // CHECK runs two cycles after the last bit, once the final shift has landed.
        if (!abort && (r_state == S_CHECK)) begin
          r_crc_ok <= (crc_in == RESIDUE);
          r_done   <= 1'b1;
        end
        if (!abort && (r_state == S_FAIL)) begin
          r_len_err <= 1'b1;
          r_crc_ok  <= 1'b0;
          r_done    <= 1'b1;
        end
      end
    end
  end

`ifdef CRC16_FRAME_STATS_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if (r_done && !r_crc_ok && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end

  assign err_count = r_err_count;
`endif

  assign crc_clr   = r_crc_clr;
  assign crc_shift = r_crc_shift;
  assign crc_bit   = r_crc_bit;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign crc_ok    = r_crc_ok;
  assign len_err   = r_len_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Bench for crc16_frame_ctrl: behavioural CRC16 engine, vector table, corner sequences, random frames.
module tb_crc16_frame_ctrl;

  localparam int LEN_W   = 10;
  localparam int MIN_LEN = 17;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_start = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             abort = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic [15:0]      crc_in;
  logic             crc_clr, crc_shift, crc_bit, busy, done, crc_ok, len_err;
  logic [2:0]       dbg_state;

  crc16_frame_ctrl #(.LEN_W(LEN_W), .RESIDUE(16'h1D0F), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in), .crc_in(crc_in),
    .crc_clr(crc_clr), .crc_shift(crc_shift), .crc_bit(crc_bit), .busy(busy),
    .done(done), .crc_ok(crc_ok), .len_err(len_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / engine ----------------
  always #5 clk = ~clk;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] eng = 16'hFFFF;
  always @(posedge clk) begin
    if (crc_clr) eng <= 16'hFFFF;
    else if (crc_shift) eng <= crc_step(eng, crc_bit);
  end
  assign crc_in = eng;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- monitor ----------------
  int          shift_cnt = 0;
  int          done_cnt  = 0;
  int          d_cyc     = 0;
  logic        d_ok      = 1'b0;
  logic        d_le      = 1'b0;
  logic [15:0] d_crc     = 16'h0;
  always @(negedge clk) begin
    if (crc_shift) shift_cnt++;
    if (done) begin
      done_cnt++;
      d_cyc = cyc;
      d_ok  = crc_ok;
      d_le  = len_err;
      d_crc = crc_in;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];   // {crc_ok, len_err} per frame
  logic       fb[0:1023];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload MSB-first (random bits beyond 32), then ones-complement CRC, then optional bit flip.
  task automatic build_frame(input int plen, input logic [31:0] payload, input int flip);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < plen; i++) begin
      fb[i] = (plen <= 32) ? payload[plen-1-i] : 1'($urandom_range(0, 1));
      c = crc_step(c, fb[i]);
    end
    for (int j = 0; j < 16; j++) fb[plen+j] = ~c[15-j];
    if (flip >= 0) fb[flip] = ~fb[flip];
  endtask

  function automatic logic model_ok(input int len);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) c = crc_step(c, fb[i]);
    model_ok = (c == 16'h1D0F);
  endfunction

  // ---------------- drivers ----------------
  task automatic send_bits(input int nbits, input int max_gap, output int last_c);
    last_c = cyc;
    for (int i = 0; i < nbits; i++) begin
      repeat ($urandom_range(0, max_gap)) tick;
      bit_valid = 1'b1;
      bit_in    = fb[i];
      last_c    = cyc;
      tick;
      bit_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input int nbits, input int max_gap,
                            input int trailing, output int start_c, output int last_c);
    cmd_start = 1'b1;
    cmd_len   = LEN_W'(len);
    start_c   = cyc;
    tick;
    cmd_start = 1'b0;
    send_bits(nbits, max_gap, last_c);
    if (nbits == 0) last_c = start_c;
    for (int t = 0; t < trailing; t++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom_range(0, 1));
      tick;
      bit_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input string name, input int base_done, input int base_shift,
                              input int exp_cyc, input int exp_shifts);
    logic [1:0] exp;
    int k;
    k = 0;
    while (done_cnt == base_done && k < 40) begin
      tick;
      k++;
    end
    exp = exp_q.pop_front();
    check({name, " done_count"}, 32'(done_cnt - base_done), 1);
    check({name, " done_cycle"}, 32'(d_cyc), 32'(exp_cyc));
    check({name, " ok_lenerr"}, {30'd0, d_ok, d_le}, {30'd0, exp});
    check({name, " shifts"}, 32'(shift_cnt - base_shift), 32'(exp_shifts));
    if (exp[1]) check({name, " residue"}, {16'd0, d_crc}, 32'h1D0F);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          plen;
    logic [31:0] payload;
    int          flip;
    int          len;
    int          gap;
    int          trail;
    logic        exp_ok;
    logic        exp_le;
  } vec_t;

  vec_t vt[10];

  task automatic run_vec(input string name, input vec_t v);
    int sc, lc, bd, bs, nb;
    if (v.len >= MIN_LEN) build_frame(v.plen, v.payload, v.flip);
    nb = (v.len >= MIN_LEN) ? v.len : 0;
    exp_q.push_back({v.exp_ok, v.exp_le});
    bd = done_cnt;
    bs = shift_cnt;
    send_frame(v.len, nb, v.gap, v.trail, sc, lc);
    finish_frame(name, bd, bs, (v.len < MIN_LEN) ? sc + 2 : lc + 3, nb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, lc, bd, bs, len, plen, flip;
    logic ok;
    vec_t v;

    //      plen  payload        flip len   gap trail ok  le
    vt[0] = '{8,    32'hC1,       -1,  24,   0,  0,   1,  0};
    vt[1] = '{8,    32'hC1,        3,  24,   0,  0,   0,  0};
    vt[2] = '{0,    32'h0,        -1,  16,   0,  0,   0,  1};
    vt[3] = '{8,    32'hC1,       -1,  24,   3,  5,   1,  0};
    vt[4] = '{1,    32'h1,        -1,  17,   0,  0,   1,  0};
    vt[5] = '{16,   32'hBEEF,     -1,  32,   1,  2,   1,  0};
    vt[6] = '{0,    32'h0,        -1,   0,   0,  3,   0,  1};
    vt[7] = '{32,   32'hDEADBEEF, 40,  48,   0,  0,   0,  0};
    vt[8] = '{1,    32'h0,        -1,  17,   2,  1,   1,  0};
    vt[9] = '{1007, 32'h0,        -1, 1023,  0,  0,   1,  0};

    // Reset state while reset is held.
    repeat (3) tick;
    check("reset_outputs", {25'd0, crc_clr, crc_shift, crc_bit, busy, done, crc_ok, len_err},
          {25'd0, 7'b1000000});
    reset = 1'b0;
    tick;
    check("idle_after_reset", {30'd0, busy, crc_clr}, 32'b01);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Abort after 10 of 24 bits, then a good frame.
    build_frame(8, 32'hC1, -1);
    bd = done_cnt;
    bs = shift_cnt;
    cmd_start = 1'b1; cmd_len = LEN_W'(24);
    tick;
    cmd_start = 1'b0;
    send_bits(10, 0, lc);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_idle", {30'd0, busy, crc_clr}, 32'b01);
    repeat (6) tick;
    check("abort_no_done", 32'(done_cnt - bd), 0);
    check("abort_shifts", 32'(shift_cnt - bs), 10);
    check("abort_flags", {30'd0, crc_ok, len_err}, 0);
    v = vt[0];
    run_vec("after_abort", v);

    // Start and abort in the same cycle: start dropped.
    bd = done_cnt;
    cmd_start = 1'b1; abort = 1'b1; cmd_len = LEN_W'(24);
    tick;
    cmd_start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 0);
    repeat (4) tick;
    check("start_abort_no_done", 32'(done_cnt - bd), 0);

    // Restart while busy: only the second frame reports.
    build_frame(8, 32'hC1, -1);
    bd = done_cnt;
    bs = shift_cnt;
    cmd_start = 1'b1; cmd_len = LEN_W'(24);
    tick;
    cmd_start = 1'b0;
    send_bits(5, 0, lc);
    exp_q.push_back(2'b10);
    send_frame(24, 24, 1, 0, sc, lc);
    finish_frame("restart", bd, bs, lc + 3, 29);

    // cmd_start coinciding with the done pulse.
    build_frame(8, 32'hC1, -1);
    send_frame(24, 24, 0, 0, sc, lc);
    tick;
    tick;
    check("coinc_done", {30'd0, done, crc_ok}, 32'b11);
    cmd_start = 1'b1; cmd_len = LEN_W'(16);
    tick;
    cmd_start = 1'b0;
    check("coinc_cleared", {29'd0, crc_ok, len_err, busy}, 32'b001);
    tick;
    check("coinc_short_done", {29'd0, done, crc_ok, len_err}, 32'b101);
    tick;

    // Asynchronous reset during RUN.
    build_frame(8, 32'hC1, -1);
    bd = done_cnt;
    cmd_start = 1'b1; cmd_len = LEN_W'(24);
    tick;
    cmd_start = 1'b0;
    send_bits(6, 0, lc);
    check("pre_reset_shift", {31'd0, crc_shift}, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {25'd0, crc_clr, crc_shift, crc_bit, busy, done, crc_ok, len_err},
          {25'd0, 7'b1000000});
    @(negedge clk);
    reset = 1'b0;
    tick;
    repeat (3) tick;
    check("reset_no_done", 32'(done_cnt - bd), 0);
    v = vt[0];
    run_vec("after_reset", v);

    // Random frames against the residue model.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(0, MIN_LEN - 1);
        exp_q.push_back(2'b01);
        bd = done_cnt;
        bs = shift_cnt;
        send_frame(len, 0, 0, $urandom_range(0, 3), sc, lc);
        finish_frame($sformatf("rnd%0d", r), bd, bs, sc + 2, 0);
      end else begin
        plen = $urandom_range(1, 48);
        flip = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, plen + 15);
        build_frame(plen, $urandom, flip);
        len = plen + 16;
        ok  = model_ok(len);
        exp_q.push_back({ok, 1'b0});
        bd = done_cnt;
        bs = shift_cnt;
        send_frame(len, len, $urandom_range(0, 2), $urandom_range(0, 3), sc, lc);
        finish_frame($sformatf("rnd%0d", r), bd, bs, lc + 3, len);
      end
    end

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
